sram_tile_reader: RTL and testbench
===================================

// Module: sram_tile_reader
// PURPOSE
//  Read-side DMA stage for the 32K x 16 dual-port activation SRAM.
//  - Drives SRAM port B address and consumes port B read data.
//  - Walks a 2-D tile: rows x cols words, row pitch = row_stride.
//  - Emits the tile as a valid/ready word stream to the downstream MAC array.
//  - Internal FIFO absorbs the fixed 1-cycle SRAM read latency under backpressure.
// PARAMETERS
//  ADDR_W      15  SRAM word-address width (matches SRAM port B address)
//  DATA_W      16  SRAM word width (matches SRAM port B read data)
//  DIM_W       8   width of rows/cols fields
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       command strobe; sampled only in IDLE
//  base_addr    in   ADDR_W  address of tile word (0,0)
//  rows         in   DIM_W   tile rows
//  cols         in   DIM_W   tile columns
//  row_stride   in   ADDR_W  address delta between row starts
//  busy         out  1       high from accepted start until done
//  done         out  1       1-cycle pulse, tile fully delivered
//  sram_b_addr  out  ADDR_W  to SRAM port_b_addr
//  sram_b_rdata in   DATA_W  from SRAM port_b_rdata; valid 1 cycle after addr
//  out_valid    out  1       stream word valid
//  out_ready    in   1       downstream accept
//  out_data     out  DATA_W  stream word
//  out_last     out  1       marks final word of tile (with out_valid)
// BEHAVIOUR
//  - Async reset: FSM=IDLE; busy, done, out_valid, out_last = 0;
//    sram_b_addr = 0; FIFO empty; counters and in-flight flag cleared.
//  - Reset mid-tile aborts the tile: no done pulse, FIFO contents discarded.
//  - FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE: on start, latch command, busy=1.
//    rows==0 or cols==0: done pulse next cycle, stay IDLE, no reads, no output.
//    Otherwise go to ISSUE.
//  - ISSUE: issue one read per cycle when (fifo_count + inflight) < FIFO_DEPTH.
//    Issued reads follow row-major order: addr = row_base + col.
//    Column wraps to 0 after cols-1; row_base += row_stride.
//    Address arithmetic is modulo 2^ADDR_W; wrap is silent, not an error.
//    After issuing word rows*cols-1, go to DRAIN.
//  - Read pipeline: address registered -> rdata captured into FIFO next cycle.
//    inflight is the 1-bit flag for that capture.
//    The last-word tag travels with the data into the FIFO.
//  - Stream: out_valid = FIFO non-empty; pop on out_valid & out_ready.
//    out_data and out_last are stable while out_valid & !out_ready.
//    out_last = 1 only on word rows*cols-1.
//  - DRAIN: wait until the last word is popped; then done=1 for 1 cycle,
//    busy=0, IDLE.
//  - start during busy is ignored.
//    start in the done cycle is accepted; FSM is already IDLE.
//  - Latency with out_ready=1, start accepted at cycle 0:
//    addr cycle 1, capture cycle 2, out_valid cycle 3.
//    Then 1 word/cycle sustained.
//  - Simultaneous FIFO push and pop: count unchanged; never overflows.
//    An overflow attempt is an assertion failure.
//  - sram_b_addr holds its last value when not issuing.
// STRUCTURE
//  - Shared package mmu_pkg: ADDR_W/DATA_W constants; tile_cmd_t struct
//    {base_addr, rows, cols, row_stride}; state enum for IDLE/ISSUE/DRAIN.
//  - Sub-module sync_fifo (DATA_W+1 wide, FIFO_DEPTH): registered pointers,
//    count, push/pop; reused by the write-side DMA.
//  - Top level binds sram_b_addr/sram_b_rdata to the SRAM in/out interfaces
//    (master modports). Port A is unused here.
// TESTING
//  1. base=0x0010, rows=2, cols=3, stride=8, ready=1 ->
//     addrs 10,11,12,18,19,1A; 6 words in order; last on 6th; done 1 cycle later.
//  2. Same tile, out_ready toggled 1-of-3 cycles ->
//     identical data order, no drops/dups, FIFO never exceeds 4, data stable while stalled.
//  3. base=0x7FFE, rows=1, cols=4 ->
//     addrs 7FFE,7FFF,0000,0001 (modulo wrap).
//  4. rows=0, cols=5 -> done 1 cycle after start, zero reads, out_valid never high.
//  5. start re-pulsed while busy -> ignored. rst_n low mid-tile ->
//     all outputs 0 immediately, no done. Fresh start after reset -> correct tile.
//  6. Back-to-back: start in the done cycle ->
//     second tile's first out_valid 3 cycles later, correct contents.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types for the activation-SRAM DMA stages: SRAM geometry, tile command, walker states.
package mmu_pkg;
  localparam int SRAM_ADDR_W = 15;
  localparam int SRAM_DATA_W = 16;
  localparam int TILE_DIM_W  = 8;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] base_addr;
    logic [TILE_DIM_W-1:0]  rows;
    logic [TILE_DIM_W-1:0]  cols;
    logic [SRAM_ADDR_W-1:0] row_stride;
  } tile_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } tile_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, zero-latency read of the head entry; pushing into a full FIFO without a pop is illegal.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/sram_tile_reader.sv
// Walks a rows x cols tile of the activation SRAM via port B and streams it out valid/ready.
// First word 3 cycles after start; reads are throttled so the FIFO can absorb every in-flight word.
module sram_tile_reader
  import mmu_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int DIM_W      = TILE_DIM_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_b_addr,
  input  logic [DATA_W-1:0] sram_b_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tile_state_t       state;
  tile_cmd_t         cmd;
  logic [DIM_W-1:0]  row, col;
  logic [ADDR_W-1:0] row_off;
  logic              addr_vld, addr_last, inflight, inflight_last;
  logic [CNT_W-1:0]  fifo_count, pending;
  logic              fifo_empty, pop, issue, word_last;
  logic [DATA_W:0]   fifo_head;

  // addr_vld: address on the bus this cycle; inflight: its read data is on sram_b_rdata now.
  assign pending   = fifo_count + CNT_W'(addr_vld) + CNT_W'(inflight);
  assign issue     = (state == ST_ISSUE) && (pending < CNT_W'(FIFO_DEPTH));
  assign word_last = (row == cmd.rows - DIM_W'(1)) && (col == cmd.cols - DIM_W'(1));

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
  assign out_last  = out_valid && fifo_head[DATA_W];

  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, sram_b_rdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd           <= '0;
      row           <= '0;
      col           <= '0;
      row_off       <= '0;
      addr_vld      <= 1'b0;
      addr_last     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      sram_b_addr   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      addr_vld      <= issue;
      addr_last     <= issue && word_last;
      inflight      <= addr_vld;
      inflight_last <= addr_last;
      if (issue) sram_b_addr <= cmd.base_addr + row_off + ADDR_W'(col);

      case (state)
        ST_IDLE: begin
          if (busy) begin
            // Empty tile accepted last cycle: report completion without touching the SRAM.
            busy <= 1'b0;
            done <= 1'b1;
          end else if (start) begin
            cmd     <= '{base_addr: base_addr, rows: rows, cols: cols, row_stride: row_stride};
            busy    <= 1'b1;
            row     <= '0;
            col     <= '0;
            row_off <= '0;
            if (rows != '0 && cols != '0) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (word_last) begin
              state <= ST_DRAIN;
            end else if (col == cmd.cols - DIM_W'(1)) begin
              col     <= '0;
              row     <= row + DIM_W'(1);
              row_off <= row_off + cmd.row_stride;
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_tile_reader.sv
// Directed bench for sram_tile_reader with a 1-cycle-latency SRAM model whose word is a fixed function of its address.
`timescale 1ns/1ps
module tb_sram_tile_reader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] base_addr;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [14:0] row_stride;
  logic        busy;
  logic        done;
  logic [14:0] sram_b_addr;
  logic [15:0] sram_b_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int          n_cmp;
  int          n_bad;
  logic [14:0] exp_addr [16];

  sram_tile_reader u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .rows         (rows),
    .cols         (cols),
    .row_stride   (row_stride),
    .busy         (busy),
    .done         (done),
    .sram_b_addr  (sram_b_addr),
    .sram_b_rdata (sram_b_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  function automatic logic [15:0] word_at(input logic [14:0] a);
    return {1'b1, a} ^ 16'h2A5A;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) sram_b_rdata <= word_at(sram_b_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full-throughput tile run: checks every cycle from accept to the done pulse against exp_addr.
  task automatic run_tile(input string tag, input logic [14:0] base, input logic [7:0] r,
                          input logic [7:0] c, input logic [14:0] stride, input bit repulse);
    int n;
    n = int'(r) * int'(c);
    base_addr = base; rows = r; cols = c; row_stride = stride; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_acc"}, 32'(busy), 32'd1);
    check({tag, ".vld_acc"}, 32'(out_valid), 32'd0);
    for (int cyc = 1; cyc <= n + 3; cyc++) begin
      if (repulse && cyc == 1) begin
        start = 1'b1; base_addr = 15'h5555; rows = 8'd9; cols = 8'd9; row_stride = 15'h0003;
      end
      if (cyc == 2) start = 1'b0;
      tick();
      if (cyc <= n) check($sformatf("%s.addr%0d", tag, cyc), 32'(sram_b_addr), 32'(exp_addr[cyc-1]));
      else check($sformatf("%s.addr_hold%0d", tag, cyc), 32'(sram_b_addr), 32'(exp_addr[n-1]));
      if (cyc >= 3 && cyc <= n + 2) begin
        check($sformatf("%s.vld%0d", tag, cyc), 32'(out_valid), 32'd1);
        check($sformatf("%s.data%0d", tag, cyc), 32'(out_data), 32'(word_at(exp_addr[cyc-3])));
        check($sformatf("%s.last%0d", tag, cyc), 32'(out_last), 32'(cyc == n + 2));
      end else begin
        check($sformatf("%s.novld%0d", tag, cyc), 32'(out_valid), 32'd0);
      end
      check($sformatf("%s.done%0d", tag, cyc), 32'(done), 32'(cyc == n + 3));
      check($sformatf("%s.busy%0d", tag, cyc), 32'(busy), 32'(cyc < n + 3));
    end
  endtask

  initial begin
    int   got;
    bit   seen_done;
    bit   held_vld;
    logic [15:0] held_data;
    logic        held_last;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; rows = '0; cols = '0; row_stride = '0;
    out_ready = 1'b1;
    #2;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.last", 32'(out_last), 32'd0);
    check("rst.addr", 32'(sram_b_addr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic 2x3 tile, then a second tile started in the done cycle.
    exp_addr[0] = 15'h010; exp_addr[1] = 15'h011; exp_addr[2] = 15'h012;
    exp_addr[3] = 15'h018; exp_addr[4] = 15'h019; exp_addr[5] = 15'h01A;
    run_tile("t1", 15'h0010, 8'd2, 8'd3, 15'h0008, 1'b0);
    exp_addr[0] = 15'h100; exp_addr[1] = 15'h101; exp_addr[2] = 15'h102;
    run_tile("t6", 15'h0100, 8'd1, 8'd3, 15'h0000, 1'b0);
    tick();

    // Same 2x3 tile with out_ready high one cycle in three.
    exp_addr[0] = 15'h010; exp_addr[1] = 15'h011; exp_addr[2] = 15'h012;
    exp_addr[3] = 15'h018; exp_addr[4] = 15'h019; exp_addr[5] = 15'h01A;
    base_addr = 15'h0010; rows = 8'd2; cols = 8'd3; row_stride = 15'h0008; start = 1'b1;
    tick();
    start = 1'b0;
    got = 0; seen_done = 1'b0; held_vld = 1'b0; held_data = '0; held_last = 1'b0;
    for (int cyc = 1; cyc < 80 && !seen_done; cyc++) begin
      tick();
      out_ready = (cyc % 3 == 0);
      if (held_vld) begin
        check($sformatf("t2.hold_vld%0d", cyc), 32'(out_valid), 32'd1);
        check($sformatf("t2.hold_data%0d", cyc), 32'(out_data), 32'(held_data));
        check($sformatf("t2.hold_last%0d", cyc), 32'(out_last), 32'(held_last));
        held_vld = 1'b0;
      end
      check($sformatf("t2.fifo_cnt%0d", cyc), 32'(u_dut.fifo_count <= 3'd4), 32'd1);
      if (done) begin
        check("t2.word_count", 32'(got), 32'd6);
        seen_done = 1'b1;
      end else if (out_valid) begin
        if (out_ready) begin
          check($sformatf("t2.in_range%0d", got), 32'(got < 6), 32'd1);
          if (got < 6) begin
            check($sformatf("t2.data%0d", got), 32'(out_data), 32'(word_at(exp_addr[got])));
            check($sformatf("t2.last%0d", got), 32'(out_last), 32'(got == 5));
          end
          got++;
        end else begin
          held_data = out_data; held_last = out_last; held_vld = 1'b1;
        end
      end
    end
    check("t2.done_seen", 32'(seen_done), 32'd1);
    out_ready = 1'b1;
    tick();

    // Address wrap at the top of the SRAM.
    exp_addr[0] = 15'h7FFE; exp_addr[1] = 15'h7FFF; exp_addr[2] = 15'h0000; exp_addr[3] = 15'h0001;
    run_tile("t3", 15'h7FFE, 8'd1, 8'd4, 15'h0000, 1'b0);
    tick();

    // Empty tile: done next cycle, no reads, no output.
    base_addr = 15'h0040; rows = 8'd0; cols = 8'd5; row_stride = 15'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4.busy0", 32'(busy), 32'd1);
    check("t4.done0", 32'(done), 32'd0);
    check("t4.vld0", 32'(out_valid), 32'd0);
    tick();
    check("t4.done1", 32'(done), 32'd1);
    check("t4.busy1", 32'(busy), 32'd0);
    check("t4.vld1", 32'(out_valid), 32'd0);
    check("t4.addr1", 32'(sram_b_addr), 32'h0001);
    tick();
    check("t4.done2", 32'(done), 32'd0);
    check("t4.vld2", 32'(out_valid), 32'd0);
    check("t4.addr2", 32'(sram_b_addr), 32'h0001);

    // start re-pulsed while busy must not disturb the running tile.
    exp_addr[0] = 15'h200; exp_addr[1] = 15'h201; exp_addr[2] = 15'h210; exp_addr[3] = 15'h211;
    run_tile("t5a", 15'h0200, 8'd2, 8'd2, 15'h0010, 1'b1);
    tick();

    // Asynchronous reset in the middle of a 3x3 tile.
    base_addr = 15'h0400; rows = 8'd3; cols = 8'd3; row_stride = 15'h0020; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("t5b.vld_pre", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5b.busy", 32'(busy), 32'd0);
    check("t5b.done", 32'(done), 32'd0);
    check("t5b.vld", 32'(out_valid), 32'd0);
    check("t5b.last", 32'(out_last), 32'd0);
    check("t5b.data", 32'(out_data), 32'd0);
    check("t5b.addr", 32'(sram_b_addr), 32'd0);
    tick();
    check("t5b.done_rst", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5b.done_after", 32'(done), 32'd0);
    check("t5b.vld_after", 32'(out_valid), 32'd0);

    exp_addr[0] = 15'h400; exp_addr[1] = 15'h401; exp_addr[2] = 15'h402;
    exp_addr[3] = 15'h420; exp_addr[4] = 15'h421; exp_addr[5] = 15'h422;
    exp_addr[6] = 15'h440; exp_addr[7] = 15'h441; exp_addr[8] = 15'h442;
    run_tile("t5c", 15'h0400, 8'd3, 8'd3, 15'h0020, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
